// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one physical-memory port between icache and dcache
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   i_pmem_* / d_pmem_*  : icache / dcache pmem-side interfaces (read, write, address, wdata in; rdata, resp out)
//   pmem_*               : shared physical-memory port (read, write, address, wdata out; rdata, resp in)
module cache_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_pmem_read,
  input  logic                   i_pmem_write,
  input  logic [ADDR_WIDTH-1:0]  i_pmem_address,
  input  logic [BLOCK_WIDTH-1:0] i_pmem_wdata,
  output logic [BLOCK_WIDTH-1:0] i_pmem_rdata,
  output logic                   i_pmem_resp,
  input  logic                   d_pmem_read,
  input  logic                   d_pmem_write,
  input  logic [ADDR_WIDTH-1:0]  d_pmem_address,
  input  logic [BLOCK_WIDTH-1:0] d_pmem_wdata,
  output logic [BLOCK_WIDTH-1:0] d_pmem_rdata,
  output logic                   d_pmem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [BLOCK_WIDTH-1:0] pmem_wdata,
  input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
  input  logic                   pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = icache served last, 1 = dcache

  logic req_i, req_d;
  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (req_i && (!req_d || last_grant_q)) begin
          state_d      = GRANT_I;
          last_grant_d = 1'b0;
        end else if (req_d) begin
          state_d      = GRANT_D;
          last_grant_d = 1'b1;
        end
      end
      // Always pass through IDLE after a completion so the served cache can
      // drop its request before it is considered again.
      GRANT_I, GRANT_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Port mux is decoded straight from the state flop so an async reset
  // silences the memory port without waiting for a clock edge.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      GRANT_I: begin
        pmem_write   = i_pmem_write;
        pmem_read    = i_pmem_read & ~i_pmem_write;  // write wins a read/write conflict
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_resp  = pmem_resp;
      end
      GRANT_D: begin
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  // Read data goes to both caches; only the granted side sees resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;
  localparam int AW    = 16;
  localparam int BW    = 128;
  localparam int LIMIT = 20;
  localparam int N_TXN = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_pmem_read = 0, i_pmem_write = 0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [BW-1:0] i_pmem_wdata = '0;
  logic [BW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 0, d_pmem_write = 0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [BW-1:0] d_pmem_wdata = '0;
  logic [BW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // op: 0 = read, 1 = write, 2 = read+write asserted together
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } req_t;

  req_t          exp_req_i[$], exp_req_d[$];
  logic [BW-1:0] exp_rsp_i[$], exp_rsp_d[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mem_en = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [BW+AW+3:0] act, input logic [BW+AW+3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit side, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] w);
    if (!side) begin
      i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = w;
    end else begin
      d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = w;
    end
  endtask

  // Random requester: issues n block transactions, holding each until its resp.
  task automatic run_requester(input bit side, input int n);
    req_t r;
    int   waited;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r.op    = 2'($urandom_range(0, 2));
      r.addr  = {side, 15'($urandom)};  // top bit tags the owner
      r.wdata = {$urandom, $urandom, $urandom, $urandom};
      set_req(side, r.op != 2'd1, r.op != 2'd0, r.addr, r.wdata);
      if (!side) exp_req_i.push_back(r); else exp_req_d.push_back(r);
      waited = 0;
      while (1) begin
        @(negedge clk);
        if (side ? d_pmem_resp : i_pmem_resp) break;
        waited++;
        if (waited > LIMIT) break;
      end
      chk(side ? "d_wait_bound" : "i_wait_bound", (BW+AW+4)'(waited > LIMIT), '0);
      @(posedge clk); #1;
      set_req(side, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Memory model + pmem-side scoreboard. Grant choice follows the
  // round-robin rule: lone requester wins, on a tie the one not served last.
  initial begin : memory
    bit            busy = 0, idle_chk = 0, last_served = 1, prev_i = 0, prev_d = 0;
    bit            win, cur_act, resp_next;
    int            lat = 0;
    req_t          cur;
    logic [BW-1:0] rd;
    forever begin
      @(negedge clk);
      resp_next = 0;
      if (mem_en) begin
        cur_act = pmem_read | pmem_write;
        if (!busy) begin
          if (idle_chk) chk("turnaround_idle", (BW+AW+4)'(cur_act), '0);
          idle_chk = 0;
          if (cur_act) begin
            if (!prev_i && !prev_d) chk("spurious_grant", 1, 0);
            win = (prev_i && prev_d) ? !last_served : !prev_i;
            if ((win ? exp_req_d.size() : exp_req_i.size()) == 0) begin
              chk("grant_queue_empty", 1, 0);
            end else begin
              cur         = win ? exp_req_d.pop_front() : exp_req_i.pop_front();
              busy        = 1;
              last_served = win;
              lat         = $urandom_range(1, 4);
            end
          end else begin
            chk("idle_outputs", {i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata}, '0);
          end
        end
        if (busy) begin
          chk("grant_mirror", {pmem_read, pmem_write, pmem_address, pmem_wdata},
              {cur.op == 2'd0, cur.op != 2'd0, cur.addr, cur.wdata});
          if (pmem_resp) begin
            busy     = 0;
            idle_chk = 1;
          end else begin
            lat--;
            resp_next = (lat == 0);
          end
        end
      end
      prev_i = i_pmem_read | i_pmem_write;
      prev_d = d_pmem_read | d_pmem_write;
      @(posedge clk); #1;
      if (mem_en) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        if (resp_next) begin
          if (last_served) exp_rsp_d.push_back(rd); else exp_rsp_i.push_back(rd);
        end
        pmem_resp  = resp_next;
        pmem_rdata = rd;
      end
    end
  end

  // Requester-side monitor: each resp pops the expected data of that side.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (i_pmem_resp) begin
          if (exp_rsp_i.size() == 0) chk("i_resp_unexpected", 1, 0);
          else chk("i_rdata", i_pmem_rdata, exp_rsp_i.pop_front());
        end
        if (d_pmem_resp) begin
          if (exp_rsp_d.size() == 0) chk("d_resp_unexpected", 1, 0);
          else chk("d_rdata", d_pmem_rdata, exp_rsp_d.pop_front());
        end
      end
    end
  end

  initial begin : main
    int k;
    // Reset state
    @(negedge clk);
    chk("reset_outputs", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address}, '0);
    @(posedge clk); #1; reset = 0;

    // Lone icache read: one idle cycle, then pmem sees it
    @(posedge clk); #1;
    set_req(0, 1, 0, 16'h1230, '0);
    @(negedge clk);
    chk("lat_idle", {pmem_read, pmem_write}, '0);
    @(negedge clk);
    chk("lat_first", {pmem_read, pmem_write, pmem_address}, {1'b1, 1'b0, 16'h1230});
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    pmem_resp = 1; pmem_rdata = {16{8'hA5}};
    @(negedge clk);
    chk("i_read_resp", {i_pmem_resp, d_pmem_resp, i_pmem_rdata}, {1'b1, 1'b0, {16{8'hA5}}});
    @(posedge clk); #1;
    pmem_resp = 0;
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("after_resp_idle", {i_pmem_resp, pmem_read, pmem_write}, '0);

    // Random phase from a fresh reset so the model's last_served matches
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0; mem_en = 1; mon_en = 1;
    fork
      run_requester(0, N_TXN);
      run_requester(1, N_TXN);
    join
    repeat (4) @(negedge clk);
    chk("queues_drained",
        (BW+AW+4)'(exp_req_i.size() + exp_req_d.size() + exp_rsp_i.size() + exp_rsp_d.size()), '0);
    @(posedge clk); #1; mem_en = 0; mon_en = 0; pmem_resp = 0;

    // Dcache read+write conflict, then async reset mid-grant
    @(posedge clk); #1;
    set_req(1, 1, 1, 16'h3000, 128'h0123456789ABCDEF0123456789ABCDEF);
    k = 0;
    do begin @(negedge clk); k++; end while (!(pmem_read | pmem_write) && k < 5);
    chk("conflict_first", {pmem_read, pmem_write, pmem_address}, {1'b0, 1'b1, 16'h3000});
    @(negedge clk);
    chk("conflict_hold", {pmem_read, pmem_write, pmem_wdata},
        {1'b0, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF});
    #2 reset = 1;
    #1 chk("async_reset", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, '0);
    set_req(0, 1, 0, 16'h1000, '0);
    @(posedge clk); #1; reset = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!(pmem_read | pmem_write) && k < 5);
    chk("post_reset_i_first", {pmem_read, pmem_write, pmem_address}, {1'b1, 1'b0, 16'h1000});
    @(posedge clk); #1; pmem_resp = 1; pmem_rdata = '1;
    @(negedge clk);
    chk("post_reset_i_resp", {i_pmem_resp, d_pmem_resp}, 2'b10);
    @(posedge clk); #1; pmem_resp = 0; set_req(0, 0, 0, '0, '0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(pmem_read | pmem_write) && k < 5);
    chk("then_d", {pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp},
        {1'b0, 1'b1, 16'h3000, 2'b00});
    @(posedge clk); #1; pmem_resp = 1;
    @(negedge clk);
    chk("d_resp", {i_pmem_resp, d_pmem_resp}, 2'b01);
    @(posedge clk); #1; pmem_resp = 0; set_req(1, 0, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
